counterup16_timer_ctrl: RTL

Sequencing controller wrapped around a 16-bit up counter. It turns the free-running counter into a programmable interval timer with start/stop/hold control, a prescaler, one-shot or periodic mode, and a terminal-count expire pulse. It sits between a control register block and the consumers of timed events.

---
 rtl/counterup16_timer_ctrl_pkg.sv | 22 ++
 rtl/counterup16_timer_ctrl_prescale_tick_gen.sv | 53 +++++
 rtl/counterup16_timer_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/counterup16_timer_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// counter_ctrl_pkg
//
// This package holds the definitions shared by the interval timer controller
// and its prescaler:
//   - timer_state_t      : controller states IDLE, RUN, HOLD and DONE
//   - DEFAULT_WIDTH      : default width of the counter and the period
//   - DEFAULT_PRE_WIDTH  : default width of the prescaler
// ----------------------------------------------------------------------------
package counter_ctrl_pkg;

    localparam int DEFAULT_WIDTH     = 16;
    localparam int DEFAULT_PRE_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } timer_state_t;

endpackage

// File: rtl/counterup16_timer_ctrl_prescale_tick_gen.sv
// ----------------------------------------------------------------------------
// prescale_tick_gen
//
// This block is a prescaler counter that divides the clock down to count
// steps. It emits one step every (i_terminal + 1) enabled cycles.
//
// Ports:
//   clock0     : clock; all state updates happen on its rising edge
//   reset      : synchronous, active-high reset; clears the prescaler
//   i_clear    : synchronous clear; takes priority over i_enable
//   i_enable   : when high, the prescaler advances this cycle
//   i_terminal : terminal value; the prescaler wraps to 0 after reaching it
//   o_step     : single-cycle strobe; high in the cycle the prescaler wraps
// ----------------------------------------------------------------------------
module prescale_tick_gen
    import counter_ctrl_pkg::*;
#(
    parameter int PRE_WIDTH = DEFAULT_PRE_WIDTH
) (
    input  logic                 clock0,
    input  logic                 reset,
    input  logic                 i_clear,
    input  logic                 i_enable,
    input  logic [PRE_WIDTH-1:0] i_terminal,
    output logic                 o_step
);

    logic [PRE_WIDTH-1:0] r_count;
    logic                 w_atTerminal;

    assign w_atTerminal = (r_count == i_terminal);

    // The strobe is combinational. The main counter therefore steps on the
    // same edge that the prescaler wraps back to zero.
    assign o_step = i_enable && w_atTerminal;

    // If enable is low, the prescaler keeps its value. This lets a held
    // timer resume from the point where it was frozen.
    always_ff @(posedge clock0) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            if (w_atTerminal) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + PRE_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/counterup16_timer_ctrl.sv
// ----------------------------------------------------------------------------
// counterup16_timer_ctrl
//
// This block is a programmable interval timer built around an up counter.
// On start, it latches the period, the prescale value and the mode. The
// counter then runs from 0 to the period, with one step every prescale+1
// cycles. At the terminal count, the block pulses expire. In periodic mode
// the counter then reloads; in one-shot mode the block stops in DONE.
//
// Ports:
//   clock0   : clock; all state updates happen on its rising edge
//   reset    : synchronous, active-high reset
//   start    : pulse; latch the settings, clear the count, enter RUN
//   stop     : pulse; abort to IDLE; the count is kept for readback
//   hold     : level; freezes counting while the state is RUN
//   periodic : 1 = auto-reload at terminal count, 0 = one-shot
//   period   : terminal count P; the counter runs 0..P inclusive
//   prescale : the counter steps once every prescale+1 cycles
//   count    : current counter value (registered)
//   expire   : one-cycle registered pulse after the terminal-count step
//   busy     : high when the state is RUN or HOLD
//   done     : high when the state is DONE (a one-shot has finished)
// ----------------------------------------------------------------------------
module counterup16_timer_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int PRE_WIDTH = DEFAULT_PRE_WIDTH
) (
    input  logic                 clock0,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 hold,
    input  logic                 periodic,
    input  logic [WIDTH-1:0]     period,
    input  logic [PRE_WIDTH-1:0] prescale,
    output logic [WIDTH-1:0]     count,
    output logic                 expire,
    output logic                 busy,
    output logic                 done
);

    timer_state_t         r_state;
    timer_state_t         w_nextState;
    logic [WIDTH-1:0]     r_count;
    logic [WIDTH-1:0]     w_nextCount;
    logic                 r_expire;
    logic                 w_nextExpire;
    logic [WIDTH-1:0]     r_period;
    logic [PRE_WIDTH-1:0] r_prescale;
    logic                 r_periodic;
    logic                 w_startTaken;
    logic                 w_tickClear;
    logic                 w_tickEnable;
    logic                 w_step;
    logic                 w_atPeriod;

    // stop wins over start. A start that arrives together with stop must
    // not disturb the latched settings.
    assign w_startTaken = start && !stop;

    // The prescaler clears on any stop or start. It advances only while the
    // timer is running unheld and no control pulse overrides the step.
    assign w_tickClear  = stop || start;
    assign w_tickEnable = (r_state == RUN) && !hold && !stop && !start;
    assign w_atPeriod   = (r_count == r_period);

    prescale_tick_gen #(
        .PRE_WIDTH (PRE_WIDTH)
    ) u_prescale_tick_gen (
        .clock0     (clock0),
        .reset      (reset),
        .i_clear    (w_tickClear),
        .i_enable   (w_tickEnable),
        .i_terminal (r_prescale),
        .o_step     (w_step)
    );

    // The settings are captured only on an accepted start. Later changes on
    // the inputs are therefore ignored until the next start.
    always_ff @(posedge clock0) begin
        if (reset) begin
            r_period   <= '0;
            r_prescale <= '0;
            r_periodic <= 1'b0;
        end else if (w_startTaken) begin
            r_period   <= period;
            r_prescale <= prescale;
            r_periodic <= periodic;
        end
    end

    // State register, main counter and registered expire pulse.
    always_ff @(posedge clock0) begin
        if (reset) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_expire <= 1'b0;
        end else begin
            r_state  <= w_nextState;
            r_count  <= w_nextCount;
            r_expire <= w_nextExpire;
        end
    end

    // Next-state and counter logic. The priority order is stop, then start,
    // then hold, then the count step. A start on a terminal edge therefore
    // suppresses that expire pulse.
    always_comb begin
        w_nextState  = r_state;
        w_nextCount  = r_count;
        w_nextExpire = 1'b0;
        if (stop) begin
            w_nextState = IDLE;
        end else if (start) begin
            w_nextState = RUN;
            w_nextCount = '0;
        end else begin
            unique case (r_state)
                RUN: begin
                    if (hold) begin
                        w_nextState = HOLD;
                    end else if (w_step) begin
                        if (w_atPeriod) begin
                            w_nextExpire = 1'b1;
                            if (r_periodic) begin
                                w_nextCount = '0;
                            end else begin
                                w_nextState = DONE;
                            end
                        end else begin
                            w_nextCount = r_count + WIDTH'(1);
                        end
                    end
                end
                HOLD: begin
                    if (!hold) begin
                        w_nextState = RUN;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign count  = r_count;
    assign expire = r_expire;
    assign busy   = (r_state == RUN) || (r_state == HOLD);
    assign done   = (r_state == DONE);

endmodule
